sr_dmem_arb: RTL

- Data-memory access controller and arbiter between the CPU load/store path and a word-wide debug/loader port.
- Shares one single-port synchronous-read SRAM between the two requesters.
- For the CPU it generates byte enables, lane-shifted write data, sign/zero-extended read data and the CPU stall.
- Misaligned CPU accesses are split into two SRAM word accesses.
- Sits between the core datapath and the data SRAM.

---
 rtl/sr_dmem_arb.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sr_dmem_arb.sv
// sr_dmem_arb: data-memory access controller and arbiter.
//
// Shares one single-port, synchronous-read SRAM between the CPU load/store
// path and a word-wide debug/loader port. For the CPU it produces byte
// enables, lane-shifted store data, sign/zero-extended load data and the
// stall signal. Misaligned CPU accesses become two SRAM word accesses.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cpuReq..cpuOpWord CPU request, direction, byte address, store data, size
//   cpuRData          load result, valid in the completion cycle
//   cpuStall          CPU must hold its current instruction
//   dbgReq..dbgWData  debug request (held until dbgAck), word address, data
//   dbgRData, dbgAck  debug read data and one-cycle completion pulse
//   mem*              SRAM strobe, byte write enables, word address, data;
//                     memRData is valid the cycle after a read strobe
module sr_dmem_arb #(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [31:0]       cpuAddr,
    input  logic [31:0]       cpuWData,
    input  logic              cpuSign,
    input  logic              cpuOpByte,
    input  logic              cpuOpHalf,
    input  logic              cpuOpWord,
    output logic [31:0]       cpuRData,
    output logic              cpuStall,
    input  logic              dbgReq,
    input  logic              dbgWe,
    input  logic [MEM_AW-1:0] dbgAddr,
    input  logic [31:0]       dbgWData,
    output logic [31:0]       dbgRData,
    output logic              dbgAck,
    output logic              memEn,
    output logic [3:0]        memWe,
    output logic [MEM_AW-1:0] memAddr,
    output logic [31:0]       memWData,
    input  logic [31:0]       memRData
);

    typedef enum logic [2:0] {IDLE, CRD1, CRD2, CWR2, DBG} state_t;

    state_t      stateReg, stateNext;
    logic        rrDbgReg, rrDbgNext;
    logic [31:0] capReg, capNext;
    logic [31:0] dbgRDataReg;

    // Address bits above the SRAM range are deliberately ignored.
    logic unusedAddrBits;
    assign unusedAddrBits = ^cpuAddr[31:MEM_AW+2];

    // ---------------- CPU access decode ----------------
    logic [2:0]        sizeN;
    logic [1:0]        offs;
    logic [4:0]        laneShift;
    logic [MEM_AW-1:0] wordA, wordB;
    logic              misaligned;
    logic [7:0]        sizeMask, mask8;
    logic [31:0]       wdataA, wdataB;

    always_comb begin
        if (cpuOpWord)      sizeN = 3'd4;
        else if (cpuOpHalf) sizeN = 3'd2;
        else if (cpuOpByte) sizeN = 3'd1;
        else                sizeN = 3'd4;
    end

    assign offs       = cpuAddr[1:0];
    assign laneShift  = {offs, 3'b000};
    assign wordA      = cpuAddr[MEM_AW+1:2];
    assign wordB      = wordA + {{(MEM_AW-1){1'b0}}, 1'b1};   // wraps at top of memory
    assign misaligned = ({2'b00, offs} + {1'b0, sizeN}) > 4'd4;

    assign sizeMask = (sizeN == 3'd1) ? 8'h01 : (sizeN == 3'd2) ? 8'h03 : 8'h0F;
    assign mask8    = sizeMask << offs;
    assign wdataA   = cpuWData << laneShift;
    // Only used when misaligned, so offs is never 0 and the shift stays below 32.
    assign wdataB   = cpuWData >> (6'd32 - {1'b0, laneShift});

    // ---------------- Load data combine ----------------
    // CRD2 joins the captured low word with the second read; otherwise the
    // upper word is zero, which covers the aligned case.
    logic [31:0] loWord, hiWord, loadData;
    logic [63:0] shifted;

    assign loWord  = (stateReg == CRD2) ? capReg   : memRData;
    assign hiWord  = (stateReg == CRD2) ? memRData : 32'h0;
    assign shifted = {hiWord, loWord} >> laneShift;

    always_comb begin
        case (sizeN)
            3'd1:    loadData = {{24{cpuSign & shifted[7]}},  shifted[7:0]};
            3'd2:    loadData = {{16{cpuSign & shifted[15]}}, shifted[15:0]};
            default: loadData = shifted[31:0];
        endcase
    end

    // ---------------- Arbitration ----------------
    logic contested, cpuGrant, dbgGrant;
    assign contested = cpuReq & dbgReq;
    assign cpuGrant  = cpuReq & (~dbgReq | ~rrDbgReg);
    assign dbgGrant  = dbgReq & (~cpuReq | rrDbgReg);

    // ---------------- State register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            rrDbgReg    <= 1'b0;
            capReg      <= 32'h0;
            dbgRDataReg <= 32'h0;
        end else begin
            stateReg    <= stateNext;
            rrDbgReg    <= rrDbgNext;
            capReg      <= capNext;
            dbgRDataReg <= dbgRData;
        end
    end

    // Debug read data is presented directly from the SRAM in the ack cycle
    // and held afterwards; writes leave it untouched.
    assign dbgAck   = (stateReg == DBG);
    assign dbgRData = (stateReg == DBG && !dbgWe) ? memRData : dbgRDataReg;

    // ---------------- Next state / outputs ----------------
    always_comb begin
        stateNext = stateReg;
        rrDbgNext = rrDbgReg;
        capNext   = capReg;
        memEn     = 1'b0;
        memWe     = 4'h0;
        memAddr   = '0;
        memWData  = 32'h0;
        cpuStall  = 1'b0;
        cpuRData  = 32'h0;

        case (stateReg)
            IDLE: begin
                if (contested) rrDbgNext = ~rrDbgReg;
                if (cpuGrant) begin
                    memEn   = 1'b1;
                    memAddr = wordA;
                    if (cpuWe) begin
                        memWe    = mask8[3:0];
                        memWData = wdataA;
                        if (misaligned) begin
                            cpuStall  = 1'b1;
                            stateNext = CWR2;
                        end
                    end else begin
                        cpuStall  = 1'b1;
                        stateNext = CRD1;
                    end
                end else if (dbgGrant) begin
                    memEn     = 1'b1;
                    memAddr   = dbgAddr;
                    memWe     = dbgWe ? 4'hF : 4'h0;
                    memWData  = dbgWData;
                    cpuStall  = cpuReq;
                    stateNext = DBG;
                end
            end
            CRD1: begin
                if (misaligned) begin
                    capNext   = memRData;
                    memEn     = 1'b1;
                    memAddr   = wordB;
                    cpuStall  = 1'b1;
                    stateNext = CRD2;
                end else begin
                    cpuRData  = loadData;
                    stateNext = IDLE;
                end
            end
            CRD2: begin
                cpuRData  = loadData;
                stateNext = IDLE;
            end
            CWR2: begin
                memEn     = 1'b1;
                memAddr   = wordB;
                memWe     = mask8[7:4];
                memWData  = wdataB;
                stateNext = IDLE;
            end
            DBG: begin
                cpuStall  = cpuReq;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule
